// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller.
// State encoding is fixed so other blocks can decode it directly.
package serial_add_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// Purely combinational 1-bit full adder, time-shared by the serial controller.
module fa (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one full adder, LSB first, one bit per RUN cycle.
// sum/cout update only on the edge that enters DONE and hold otherwise.
module serial_add_ctrl
   import serial_add_ctrl_pkg::*;
#(
   parameter int WIDTH = 8,
   localparam int CW   = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   state_t           state;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] res;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic             fa_sum;
   logic             fa_cout;
   logic [WIDTH-1:0] res_next;

   fa u_fa (
      .a    (op_a[0]),
      .b    (op_b[0]),
      .cin  (carry),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // New bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB result.
   assign res_next = WIDTH'({fa_sum, res} >> 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         op_a  <= '0;
         op_b  <= '0;
         res   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  op_a  <= a;
                  op_b  <= b;
                  carry <= cin;
                  res   <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               op_a  <= op_a >> 1;
               op_b  <= op_b >> 1;
               res   <= res_next;
               carry <= fa_cout;
               cnt   <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1)) begin
                  sum   <= res_next;
                  cout  <= fa_cout;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and randomised checks of serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_done = -1;

   logic [W-1:0] exp_sum = '0;
   logic         exp_cout = 1'b0;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Minimum spacing between done pulses, measured in clock edges.
   always @(posedge clk) begin
      cyc++;
      #1;
      if (!rst_n) last_done = -1;
      else if (done) begin
         if (last_done >= 0) check("done_spacing", 64'(cyc - last_done >= W + 2), 64'd1);
         last_done = cyc;
      end
   end

   // Accepts one operation on the next edge, then follows it to the done pulse.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                         output int lat);
      logic [W:0] full;
      full = {1'b0, ta} + {1'b0, tb_v} + {{W{1'b0}}, tc};
      a = ta; b = tb_v; cin = tc; start = 1'b1;
      step();
      start = 1'b0;
      lat = 0;
      check("busy_after_accept", 64'(busy), 64'd1);
      while (!done && lat < 20) begin
         step();
         lat++;
         if (!done) begin
            check("busy_run", 64'(busy), 64'd1);
            check("sum_hold_run", 64'(sum), 64'(exp_sum));
         end
      end
      exp_sum  = full[W-1:0];
      exp_cout = full[W];
      check("latency", 64'(lat), 64'(W));
      check("busy_in_done", 64'(busy), 64'd0);
      check("sum", 64'(sum), 64'(exp_sum));
      check("cout", 64'(cout), 64'(exp_cout));
      step();
      check("done_one_cycle", 64'(done), 64'd0);
   endtask

   initial begin
      int lat;
      int n;
      int dones;
      logic [W:0] full;

      // Reset held with start asserted
      a = 8'hAA; b = 8'h55; start = 1'b1;
      repeat (3) step();
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_sum", 64'(sum), 64'h00);
      check("rst_cout", 64'(cout), 64'd0);
      start = 1'b0;
      rst_n = 1'b1;
      step();
      check("idle_busy", 64'(busy), 64'd0);

      run_op(8'h25, 8'h1A, 1'b0, lat);
      check("basic_sum", 64'(sum), 64'h3F);
      run_op(8'hFF, 8'h00, 1'b1, lat);
      check("ovf_sum", 64'({cout, sum}), 64'h100);
      run_op(8'hFF, 8'hFF, 1'b1, lat);
      check("ovf2_sum", 64'({cout, sum}), 64'h1FF);

      // start held through RUN and DONE with a changed operand: only one op runs
      a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
      step();
      a = 8'h80;
      dones = 0;
      n = 0;
      for (int i = 1; i <= W + 1; i++) begin
         step();
         if (done) begin
            dones++;
            n = i;
         end else if (i < W) check("ign_sum_hold", 64'(sum), 64'hFF);
      end
      start = 1'b0;
      repeat (12) begin
         step();
         if (done) dones++;
      end
      check("ign_one_done", 64'(dones), 64'd1);
      check("ign_latency", 64'(n), 64'(W));
      check("ign_sum", 64'({cout, sum}), 64'h002);
      exp_sum = 8'h02; exp_cout = 1'b0;

      // Asynchronous reset in the middle of an operation
      a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      repeat (4) step();
      check("mid_busy_before", 64'(busy), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_busy", 64'(busy), 64'd0);
      check("async_sum", 64'(sum), 64'h00);
      check("async_cout", 64'(cout), 64'd0);
      check("async_done", 64'(done), 64'd0);
      repeat (2) step();
      rst_n = 1'b1;
      dones = 0;
      repeat (12) begin
         step();
         if (done) dones++;
      end
      check("abort_no_done", 64'(dones), 64'd0);
      check("abort_sum", 64'({cout, sum}), 64'h000);
      exp_sum = '0; exp_cout = 1'b0;
      run_op(8'h12, 8'h34, 1'b1, lat);
      check("post_rst_sum", 64'({cout, sum}), 64'h047);

      // Random back-to-back: start stays high; new operands set during each DONE cycle
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      start = 1'b1;
      for (int i = 0; i < 256; i++) begin
         full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
         n = 0;
         do begin
            step();
            n++;
         end while (!done && n < 30);
         check("rnd_timeout", 64'(done), 64'd1);
         check("rnd_result", 64'({cout, sum}), 64'(full));
         a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      end
      start = 1'b0;
      repeat (3) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog expired");
   end

endmodule
